// File: rtl/npu_seq_ctrl.sv
// NPU host interface and layer sequencer: decodes host accesses into memory strobes and
// command registers, then steps through the enabled layers with a per-layer watchdog.
//   state   | meaning
//   S_IDLE  | no run active
//   S_START | layer_start pulse for layer cur
//   S_WAIT  | waiting for layer_done[cur], watchdog counting down
//   S_DONE  | run finished, result latched
//   S_ERR   | watchdog expired on layer cur
module npu_seq_ctrl #(
    parameter int N_LAYERS = 4,
    parameter int N_MEM    = 5,
    parameter int SEL_W    = 3,
    parameter int IDX_W    = 12,
    parameter int DATA_W   = 32,
    parameter int RES_W    = 24,
    parameter int CMD_SEL  = 5,
    parameter int TMO_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   we,
    input  logic [SEL_W+IDX_W-1:0] addr,
    input  logic [DATA_W-1:0]      w_data,
    output logic [DATA_W-1:0]      r_data,
    output logic                   r_valid,
    output logic [N_MEM-1:0]       mem_we,
    output logic [IDX_W-1:0]       mem_idx,
    output logic [7:0]             mem_wdata,
    output logic [N_LAYERS-1:0]    layer_start,
    input  logic [N_LAYERS-1:0]    layer_done,
    input  logic [RES_W-1:0]       result_in,
    output logic                   busy,
    output logic                   done,
    output logic                   irq
);
    localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE, S_ERR} state_t;
    state_t state, state_nxt;

    logic [SEL_W-1:0]    sel;
    logic [IDX_W-1:0]    idx;
    logic                cmd_wr, mem_wr, soft_rst, trig, mask_wr, tmo_wr;
    logic                running, start_run;
    logic [N_LAYERS-1:0] layer_mask, run_mask;
    logic [TMO_W-1:0]    tmo_reload, tmo_snap, tmo_cnt;
    logic [LW-1:0]       cur, first_k, nxt_k;
    logic                first_any, nxt_any, tmo_exp;
    logic                go_done, go_err, adv, fin;
    logic [RES_W-1:0]    result;
    logic                wr_blocked, overrun, timeout_err;
    logic [7:0]          err_layer;
    logic [DATA_W-1:0]   status, rd_val;
    logic                unused_wdata;

    assign sel       = addr[SEL_W+IDX_W-1:IDX_W];
    assign idx       = addr[IDX_W-1:0];
    assign cmd_wr    = en & we & (sel == SEL_W'(CMD_SEL));
    assign mem_wr    = en & we & (32'(sel) < N_MEM);
    assign soft_rst  = cmd_wr & (idx == IDX_W'(0));
    assign trig      = cmd_wr & (idx == IDX_W'(1));
    assign mask_wr   = cmd_wr & (idx == IDX_W'(4));
    assign tmo_wr    = cmd_wr & (idx == IDX_W'(5));
    assign running   = (state == S_START) || (state == S_WAIT);
    assign start_run = trig & ~running;
    assign tmo_exp   = (state == S_WAIT) && (tmo_snap != '0) && (tmo_cnt == TMO_W'(1));
    assign unused_wdata = ^w_data;

    always_comb begin
        first_any = 1'b0;
        first_k   = '0;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_mask[i]) begin
                first_any = 1'b1;
                first_k   = LW'(i);
            end
        end
    end

    always_comb begin
        nxt_any = 1'b0;
        nxt_k   = '0;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (run_mask[i] && (i > int'(cur))) begin
                nxt_any = 1'b1;
                nxt_k   = LW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Soft reset outranks layer_done, which outranks the watchdog.
    always_comb begin
        state_nxt = state;
        go_done   = 1'b0;
        go_err    = 1'b0;
        adv       = 1'b0;
        fin       = 1'b0;
        if (soft_rst) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (trig) begin
                        if (first_any) begin
                            state_nxt = S_START;
                        end else begin
                            state_nxt = S_DONE;
                            go_done   = 1'b1;
                        end
                    end
                end
                S_START: state_nxt = S_WAIT;
                S_WAIT: begin
                    if (layer_done[cur]) begin
                        if (nxt_any) begin
                            state_nxt = S_START;
                            adv       = 1'b1;
                        end else begin
                            state_nxt = S_DONE;
                            go_done   = 1'b1;
                            fin       = 1'b1;
                        end
                    end else if (tmo_exp) begin
                        state_nxt = S_ERR;
                        go_err    = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = running;
        done        = (state == S_DONE);
        layer_start = '0;
        if (state == S_START) layer_start[cur] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_mask  <= '1;
            tmo_reload  <= '0;
            run_mask    <= '0;
            tmo_snap    <= '0;
            tmo_cnt     <= '0;
            cur         <= '0;
            result      <= '0;
            wr_blocked  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            err_layer   <= '0;
            irq         <= 1'b0;
        end else begin
            irq <= go_done | go_err;
            if (mask_wr) layer_mask <= w_data[N_LAYERS-1:0];
            if (tmo_wr)  tmo_reload <= w_data[TMO_W-1:0];
            if (state == S_START)
                tmo_cnt <= tmo_snap;
            else if ((state == S_WAIT) && (tmo_cnt != '0))
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            if (soft_rst) begin
                result      <= '0;
                wr_blocked  <= 1'b0;
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
                err_layer   <= '0;
            end else begin
                // Mask and watchdog reload are frozen for the whole run at trigger time.
                if (start_run) begin
                    run_mask    <= layer_mask;
                    tmo_snap    <= tmo_reload;
                    cur         <= first_k;
                    wr_blocked  <= 1'b0;
                    overrun     <= 1'b0;
                    timeout_err <= 1'b0;
                    err_layer   <= '0;
                    if (!first_any) result <= '0;
                end
                if (trig & running)   overrun    <= 1'b1;
                if (mem_wr & running) wr_blocked <= 1'b1;
                if (adv)              cur        <= nxt_k;
                if (fin)              result     <= result_in;
                if (go_err) begin
                    timeout_err <= 1'b1;
                    err_layer   <= 8'(cur);
                end
            end
        end
    end

    always_comb begin
        status        = '0;
        status[15:8]  = err_layer;
        status[5]     = timeout_err;
        status[4]     = overrun;
        status[3]     = wr_blocked;
        status[1]     = busy;
        status[0]     = done;
        rd_val        = '0;
        if (sel == SEL_W'(CMD_SEL)) begin
            if (idx == IDX_W'(2))      rd_val = DATA_W'($signed(result));
            else if (idx == IDX_W'(3)) rd_val = status;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= '0;
            mem_idx   <= '0;
            mem_wdata <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else begin
            mem_we  <= '0;
            r_valid <= en & ~we;
            r_data  <= (en & ~we) ? rd_val : '0;
            if (mem_wr & ~running) begin
                mem_we    <= N_MEM'(1) << sel;
                mem_idx   <= idx;
                mem_wdata <= w_data[7:0];
            end
        end
    end
endmodule

// File: doc/npu_seq_ctrl.md
Name: npu_seq_ctrl

Overview:
Parametrised host-interface and layer sequencer for the NPU pipeline; generalises the fixed conv1->conv2->fc1->fc2 controller. Decodes a sectioned host address into memory-write strobes and command registers. Runs up to N_LAYERS compute stages in order, with a per-layer skip mask and per-layer timeout. Latches the final result and exposes result and status through a registered read port with irq.

Parameters:
N_LAYERS, 4, number of sequenced layers; bit k of the vectors is layer k, run in ascending order
N_MEM, 5, number of writable memory sections (sel 0..N_MEM-1)
SEL_W, 3, address section-select width
IDX_W, 12, address index width
DATA_W, 32, host data width
RES_W, 24, signed result width (RES_W <= DATA_W)
CMD_SEL, 5, section value decoding as command space (must be >= N_MEM)
TMO_W, 16, timeout counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  host access valid
we  in  1  1 = write, 0 = read (qualified by en)
addr  in  SEL_W+IDX_W  {sel, idx}
w_data  in  DATA_W  host write data
r_data  out  DATA_W  read data
r_valid  out  1  read data valid pulse
mem_we  out  N_MEM  one-hot memory write strobe
mem_idx  out  IDX_W  memory write index
mem_wdata  out  8  memory write byte (w_data[7:0])
layer_start  out  N_LAYERS  one-cycle start pulse per layer
layer_done  in  N_LAYERS  per-layer completion pulse
result_in  in  RES_W  signed final-layer result
busy  out  1  sequencer running
done  out  1  run complete (level)
irq  out  1  one-cycle pulse on DONE or ERR entry

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; layer_mask = all ones; tmo_reload = 0; result = 0; flags = 0.
- Write access (en&we): sel < N_MEM -> mem_we[sel], mem_idx, mem_wdata registered, 1 cycle later, for 1 cycle. Blocked while busy: no strobe, sticky wr_blocked set. sel not < N_MEM and not CMD_SEL -> ignored.
- Command writes (sel==CMD_SEL), by idx:
  - 0: soft reset. State IDLE, flags and result cleared; mask and tmo_reload kept.
  - 1: trigger.
  - 4: layer_mask <= w_data[N_LAYERS-1:0].
  - 5: tmo_reload <= w_data[TMO_W-1:0]; 0 disables timeout.
  - Other idx ignored.
- Reads (en&~we): r_valid and r_data one cycle later.
  - CMD_SEL idx 2: result, sign-extended to DATA_W.
  - CMD_SEL idx 3: status {.., err_layer[7:0] at [15:8], timeout_err[5], overrun[4], wr_blocked[3], busy[1], done[0]}.
  - Any other read: 0.
- States: IDLE, START, WAIT, DONE, ERR.
- Trigger in IDLE/DONE/ERR:
  - Clears done and flags.
  - k = lowest set mask bit. Mask 0 -> DONE next cycle, result = 0, irq.
  - Otherwise START; layer_start[k] high exactly one cycle, 1 cycle after the trigger write.
  - busy = 1 from the same cycle until DONE/ERR.
- Trigger while busy: ignored; sticky overrun set.
- START -> WAIT. Timeout counter loaded with tmo_reload.
- WAIT:
  - Only layer_done[k] is observed; done pulses from other layers are ignored.
  - On layer_done[k], next set mask bit j>k -> layer_start[j] pulses the following cycle.
  - No j -> result <= result_in, DONE next cycle (done=1, busy=0, irq pulse).
- Timeout: counter decrements each WAIT cycle when tmo_reload != 0. Reaching 0 without layer_done[k] -> ERR, timeout_err=1, err_layer=k, irq pulse.
- layer_done[k] in the same cycle the counter expires: done wins.
- done and ERR hold until the next trigger or soft reset.
- Priority in one cycle: hard reset > soft reset > layer_done > timeout. A soft reset mid-run aborts without irq; a layer_done in that cycle is ignored.
- Mask/timeout writes while busy take effect for the next run only (mask is snapshotted at trigger).
- Total latency, mask all ones, layer latencies Lk: done rises 1 + sum(Lk + 1) cycles after the trigger write.

Test Plan:
- Memory write (sel=1, idx=7, w_data=0x5A) -> next cycle mem_we=5'b00010, mem_idx=7, mem_wdata=0x5A; one cycle only.
- Full run, mask 4'b1111, each layer_done 10 cycles after its start, result_in=-3:
  - layer_start pulses 0,1,2,3 in order.
  - done and irq 45 cycles after trigger.
  - Result read returns 0xFFFFFFFD.
- Mask 4'b0101 -> only layer_start[0] and [2] pulse; layer_done[1] injected during WAIT on layer 0 is ignored; mask 0 -> done one cycle after trigger, result 0.
- tmo_reload=20, layer 2 never completes -> ERR 20 WAIT cycles after layer_start[2]; status read shows timeout_err=1, err_layer=2, busy=0; irq pulses once.
- While busy: trigger -> overrun=1, no extra start; write sel=0 -> no mem_we, wr_blocked=1; soft reset -> IDLE, flags clear, no irq.
- rst asserted mid-WAIT asynchronously -> all outputs 0 immediately; mask reads back all ones after the next trigger run.
